// File: rtl/mul_share_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// mul_share_pkg : shared types and sizing helpers for mul_share_arbiter
// rev 1.0
// ----------------------------------------------------------------------
package mul_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_W       = 16;
  localparam int DEF_TIMEOUT = 32;

  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, search starts after last_grant
// rev 1.0
// ----------------------------------------------------------------------
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_grant_i,
  input  logic            enable_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   grant_idx_o
);

  logic [IW-1:0] kk;
  logic          found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    kk          = '0;
    found       = 1'b0;
    if (enable_i) begin
      for (int i = 1; i <= NREQ; i++) begin
        kk = IW'((int'(last_grant_i) + i) % NREQ);
        if (!found && req_i[kk]) begin
          grant_o[kk] = 1'b1;
          grant_idx_o = kk;
          found       = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// mul_share_arbiter : shares one sequential multiplier core among NREQ clients
// rev 1.0
// ----------------------------------------------------------------------
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [2*W-1:0]    rsp_y,
  output logic              rsp_err,
  output logic              mul_start,
  output logic [W-1:0]      mul_ain,
  output logic [W-1:0]      mul_bin,
  input  logic              mul_done,
  input  logic [2*W-1:0]    mul_yout,
  output logic              busy,
  output logic              err_timeout
);

  localparam int            IW       = idx_width(NREQ);
  localparam int            CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [IW-1:0]   g_q, g_d, last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  y_q, y_d;
  logic            rerr_q, rerr_d, to_q, to_d;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .enable_i     (state_q == IDLE),
    .grant_o      (arb_grant),
    .grant_idx_o  (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      last_q  <= IW'(NREQ - 1);  // lane 0 wins the first search
      cnt_q   <= '0;
      y_q     <= '0;
      rerr_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      rerr_q  <= rerr_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    g_d       = g_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    rerr_d    = rerr_q;
    to_d      = to_q;
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          req_ready = arb_grant;
          a_d       = req_a[int'(arb_idx)*W +: W];
          b_d       = req_b[int'(arb_idx)*W +: W];
          g_d       = arb_idx;
          last_d    = arb_idx;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        mul_start = 1'b1;
        // a done in the final watchdog cycle still counts as success
        if (mul_done) begin
          y_d     = mul_yout;
          rerr_d  = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          y_d     = '0;
          rerr_d  = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        rsp_valid[g_q] = 1'b1;
        if (rsp_ready[g_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign mul_ain     = a_q;
  assign mul_bin     = b_q;
  assign rsp_y       = y_q;
  assign rsp_err     = rerr_q;
  assign err_timeout = to_q;

endmodule
`default_nettype wire
